dma_multich_engine: RTL



---
 rtl/dma_multich_engine_pkg.sv | 41 ++++
 rtl/dma_multich_engine_arbiter.sv | 33 +++
 rtl/dma_multich_engine.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dma_multich_engine_pkg.sv
// Shared types and constants for the multi-channel DMA engine.
package dma_pkg;

  // Sequencer states: wait for work, fetch a source word, store it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } dma_state_e;

  // Per-channel register offsets within a channel's window.
  localparam logic [3:0] SRC_OFF  = 4'h0;
  localparam logic [3:0] DST_OFF  = 4'h4;
  localparam logic [3:0] LEN_OFF  = 4'h8;
  localparam logic [3:0] CTRL_OFF = 4'hC;
  localparam int         CH_STRIDE = 16;

  // Bit positions inside the CTRL register.
  localparam int CTRL_START  = 0;
  localparam int CTRL_BUSY   = 1;
  localparam int CTRL_DONE   = 2;
  localparam int CTRL_IRQ_EN = 3;

  // Stored CTRL state of one channel; START is a strobe and is never stored.
  typedef struct packed {
    logic irqEn;
    logic done;
    logic busy;
  } ch_ctrl_t;

  // CTRL as seen by the CPU, START always reading back as zero.
  function automatic logic [3:0] ctrlReadback(input ch_ctrl_t ctrl);
    logic [3:0] value;
    value              = 4'h0;
    value[CTRL_BUSY]   = ctrl.busy;
    value[CTRL_DONE]   = ctrl.done;
    value[CTRL_IRQ_EN] = ctrl.irqEn;
    return value;
  endfunction

endpackage

// File: rtl/dma_multich_engine_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer.
module dma_rr_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_grantOh,
  output logic [IDX_W-1:0]  o_grantIdx,
  output logic              o_grantValid
);

  logic [IDX_W-1:0] w_cand;

  // Walk the channels starting at the pointer and stop at the first request.
  always_comb begin
    o_grantOh    = '0;
    o_grantIdx   = '0;
    o_grantValid = 1'b0;
    w_cand       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cand = IDX_W'((int'(i_ptr) + i) % NUM_CH);
      if (!o_grantValid && i_req[w_cand]) begin
        o_grantValid      = 1'b1;
        o_grantIdx        = w_cand;
        o_grantOh[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_multich_engine.sv
// NUM_CH-channel memory-to-memory copy engine with a CPU register port and
// one shared req/ack memory master, arbitrated word by word round-robin.
module dma_multich_engine
  import dma_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NUM_CH = 4,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic              valid,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              irq
);

  localparam int                IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W-1:0] REG_SPAN   = ADDR_W'(NUM_CH * CH_STRIDE);
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);
  localparam logic [LEN_W-1:0]  LEN_ONE    = LEN_W'(1);

  // Channel register file.
  logic [ADDR_W-1:0] r_src  [NUM_CH];
  logic [ADDR_W-1:0] r_dst  [NUM_CH];
  logic [LEN_W-1:0]  r_len  [NUM_CH];
  ch_ctrl_t          r_ctrl [NUM_CH];

  // Sequencer state; mem_wdata doubles as the word buffer between RD and WR.
  dma_state_e        r_state;
  logic [IDX_W-1:0]  r_rrPtr;
  logic [IDX_W-1:0]  r_grantIdx;
  logic [NUM_CH-1:0] r_grantOh;

  logic              w_inRange;
  logic [IDX_W-1:0]  w_chSel;
  logic [3:0]        w_regOff;
  logic              w_cpuWr;
  logic              w_wordDone;
  logic [NUM_CH-1:0] w_busyVec;
  logic [NUM_CH-1:0] w_grantOh;
  logic [IDX_W-1:0]  w_grantIdx;
  logic              w_grantAny;
  logic [DATA_W-1:0] w_readVal;

  assign w_inRange  = (addr < REG_SPAN);
  assign w_chSel    = addr[4 +: IDX_W];
  assign w_regOff   = {addr[3:2], 2'b00};
  assign w_cpuWr    = valid && wr_en && w_inRange;
  assign w_wordDone = (r_state == WR) && mem_ack;

  // Collect the BUSY flags as the arbiter request vector.
  always_comb begin
    w_busyVec = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_busyVec[c] = r_ctrl[c].busy;
    end
  end

  dma_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arbiter (
    .i_req        (w_busyVec),
    .i_ptr        (r_rrPtr),
    .o_grantOh    (w_grantOh),
    .o_grantIdx   (w_grantIdx),
    .o_grantValid (w_grantAny)
  );

  // CPU programming and hardware progress updates of every channel; the
  // hardware update is written last so a completing word beats a DONE clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_src[c]  <= '0;
        r_dst[c]  <= '0;
        r_len[c]  <= '0;
        r_ctrl[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_cpuWr && (w_chSel == IDX_W'(c))) begin
          case (w_regOff)
            SRC_OFF: if (!r_ctrl[c].busy) r_src[c] <= ADDR_W'(wdata);
            DST_OFF: if (!r_ctrl[c].busy) r_dst[c] <= ADDR_W'(wdata);
            LEN_OFF: if (!r_ctrl[c].busy) r_len[c] <= LEN_W'(wdata);
            CTRL_OFF: begin
              r_ctrl[c].irqEn <= wdata[CTRL_IRQ_EN];
              if (wdata[CTRL_DONE]) begin
                r_ctrl[c].done <= 1'b0;
              end
              if (wdata[CTRL_START] && !r_ctrl[c].busy) begin
                if (r_len[c] == '0) begin
                  r_ctrl[c].done <= 1'b1;
                end else begin
                  r_ctrl[c].busy <= 1'b1;
                  r_ctrl[c].done <= 1'b0;
                end
              end
            end
            default: ;
          endcase
        end
        if (w_wordDone && r_grantOh[c]) begin
          r_src[c] <= r_src[c] + WORD_BYTES;
          r_dst[c] <= r_dst[c] + WORD_BYTES;
          r_len[c] <= r_len[c] - LEN_ONE;
          if (r_len[c] == LEN_ONE) begin
            r_ctrl[c].busy <= 1'b0;
            r_ctrl[c].done <= 1'b1;
          end
        end
      end
    end
  end

  // Register read mux; unmapped addresses return zero.
  always_comb begin
    w_readVal = '0;
    if (w_inRange) begin
      case (w_regOff)
        SRC_OFF:  w_readVal = DATA_W'(r_src[w_chSel]);
        DST_OFF:  w_readVal = DATA_W'(r_dst[w_chSel]);
        LEN_OFF:  w_readVal = DATA_W'(r_len[w_chSel]);
        CTRL_OFF: w_readVal = DATA_W'(ctrlReadback(r_ctrl[w_chSel]));
        default:  w_readVal = '0;
      endcase
    end
  end

  // Registered read data, held until the next read access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (valid && !wr_en) begin
      rdata <= w_readVal;
    end
  end

  // Level interrupt from any channel that is done with interrupts enabled.
  always_comb begin
    irq = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      irq = irq | (r_ctrl[c].done & r_ctrl[c].irqEn);
    end
  end

  // Word sequencer: grant, read the source word, write it out, rotate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rrPtr    <= '0;
      r_grantIdx <= '0;
      r_grantOh  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantAny) begin
            r_grantIdx <= w_grantIdx;
            r_grantOh  <= w_grantOh;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= r_src[w_grantIdx];
            r_state    <= RD;
          end
        end
        RD: begin
          if (mem_ack) begin
            mem_wdata <= mem_rdata;
            mem_we    <= 1'b1;
            mem_addr  <= r_dst[r_grantIdx];
            r_state   <= WR;
          end
        end
        WR: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            r_rrPtr <= (r_grantIdx == IDX_W'(NUM_CH - 1)) ? '0 : r_grantIdx + IDX_W'(1);
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
